// File: rtl/rv32_wb_pkg.sv
// rv32_wb_pkg: load-width encodings and writeback FSM states shared by the writeback stage.
package rv32_wb_pkg;
  localparam logic [1:0] RV32_MEM_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] RV32_MEM_WIDTH_HALF = 2'b01;
  localparam logic [1:0] RV32_MEM_WIDTH_WORD = 2'b10;
  typedef enum logic [1:0] {WB_IDLE, WB_READY, WB_LOAD_WAIT} wb_state_t;
endpackage

// File: rtl/rv32_wb_if.sv
// rv32_wb_if: memory-stage inputs, data-memory return and regfile write port of the writeback stage.
// RV32_WB_BYPASS_EN adds the bypass hold-register outputs.
interface rv32_wb_if;
  logic        stall_in;
  logic        flush_in;
  logic        valid_in;
  logic [4:0]  rd_in;
  logic        rd_write_in;
  logic [31:0] result_in;
  logic        mem_read_in;
  logic [1:0]  mem_width_in;
  logic        mem_zero_extend_in;
  logic        mem_ready_in;
  logic [31:0] mem_read_value_in;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] rd_value_out;
  logic        stall_out;
  logic        retire_out;
`ifdef RV32_WB_BYPASS_EN
  logic        bypass_valid_out;
  logic [4:0]  bypass_rd_out;
  logic [31:0] bypass_value_out;
`endif
  modport master (
    output stall_in, flush_in, valid_in, rd_in, rd_write_in, result_in, mem_read_in,
           mem_width_in, mem_zero_extend_in, mem_ready_in, mem_read_value_in,
    input  rd_out, rd_write_out, rd_value_out, stall_out, retire_out
`ifdef RV32_WB_BYPASS_EN
    , input bypass_valid_out, bypass_rd_out, bypass_value_out
`endif
  );
  modport slave (
    input  stall_in, flush_in, valid_in, rd_in, rd_write_in, result_in, mem_read_in,
           mem_width_in, mem_zero_extend_in, mem_ready_in, mem_read_value_in,
    output rd_out, rd_write_out, rd_value_out, stall_out, retire_out
`ifdef RV32_WB_BYPASS_EN
    , output bypass_valid_out, bypass_rd_out, bypass_value_out
`endif
  );
endinterface

// File: rtl/rv32_load_align.sv
// rv32_load_align: picks the addressed byte/half of a loaded word and sign/zero-extends it.
module rv32_load_align
  import rv32_wb_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  width_i,
  input  logic        zero_extend_i,
  output logic [31:0] value_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  always_comb begin
    byte_v  = 8'(word_i >> {offset_i, 3'b000});
    half_v  = offset_i[1] ? word_i[31:16] : word_i[15:0];
    value_o = width_i == RV32_MEM_WIDTH_BYTE ? {{24{byte_v[7] & ~zero_extend_i}}, byte_v} :
              width_i == RV32_MEM_WIDTH_HALF ? {{16{half_v[15] & ~zero_extend_i}}, half_v} :
              word_i;
  end
endmodule

// File: rtl/rv32_writeback.sv
// rv32_writeback: final pipeline stage; captures memory-stage results, waits for load data and drives
// the regfile write port. RV32_WB_BYPASS_EN adds a one-cycle-delayed copy of each regfile write.
module rv32_writeback
  import rv32_wb_pkg::*;
(
  input logic     clk,
  input logic     reset,
  rv32_wb_if.slave bus
);
  wb_state_t   state_q, state_d;
  logic [4:0]  s1_rd_q;
  logic        s1_rd_write_q;
  logic [31:0] s1_result_q;
  logic [1:0]  s1_width_q;
  logic        s1_zext_q;
  logic        capture, resolves;
  logic [31:0] load_value, wb_value;
  logic [4:0]  rd_q;
  logic        rd_write_q;
  logic [31:0] rd_value_q;
  logic        retire_q;

  rv32_load_align u_align (
    .word_i        (bus.mem_read_value_in),
    .offset_i      (s1_result_q[1:0]),
    .width_i       (s1_width_q),
    .zero_extend_i (s1_zext_q),
    .value_o       (load_value)
  );

  assign bus.stall_out = state_q == WB_LOAD_WAIT && !bus.mem_ready_in;

  // A resolved instruction leaves S1 even when stall_in blocks a refill, so it retires exactly once.
  always_comb begin
    capture  = !bus.stall_in && !bus.stall_out;
    resolves = state_q == WB_READY || (state_q == WB_LOAD_WAIT && bus.mem_ready_in);
    wb_value = state_q == WB_LOAD_WAIT ? load_value : s1_result_q;
    state_d  = state_q;
    if (capture)
      state_d = !bus.valid_in || bus.flush_in ? WB_IDLE :
                bus.mem_read_in ? WB_LOAD_WAIT : WB_READY;
    else if (resolves)
      state_d = WB_IDLE;
  end

  always_ff @(posedge clk)
    if (reset) state_q <= WB_IDLE;
    else state_q <= state_d;

  always_ff @(posedge clk)
    if (capture) begin
      s1_rd_q       <= bus.rd_in;
      s1_rd_write_q <= bus.rd_write_in;
      s1_result_q   <= bus.result_in;
      s1_width_q    <= bus.mem_width_in;
      s1_zext_q     <= bus.mem_zero_extend_in;
    end

  always_ff @(posedge clk)
    if (reset) begin
      rd_q       <= '0;
      rd_write_q <= 1'b0;
      rd_value_q <= '0;
      retire_q   <= 1'b0;
    end else begin
      rd_write_q <= resolves && s1_rd_write_q && s1_rd_q != 5'd0;
      retire_q   <= resolves;
      if (resolves) begin
        rd_q       <= s1_rd_q;
        rd_value_q <= wb_value;
      end
    end

  assign bus.rd_out       = rd_q;
  assign bus.rd_write_out = rd_write_q;
  assign bus.rd_value_out = rd_value_q;
  assign bus.retire_out   = retire_q;

`ifdef RV32_WB_BYPASS_EN
  logic        bypass_valid_q;
  logic [4:0]  bypass_rd_q;
  logic [31:0] bypass_value_q;
  always_ff @(posedge clk)
    if (reset) begin
      bypass_valid_q <= 1'b0;
      bypass_rd_q    <= '0;
      bypass_value_q <= '0;
    end else begin
      bypass_valid_q <= rd_write_q;
      bypass_rd_q    <= rd_q;
      bypass_value_q <= rd_value_q;
    end
  assign bus.bypass_valid_out = bypass_valid_q;
  assign bus.bypass_rd_out    = bypass_rd_q;
  assign bus.bypass_value_out = bypass_value_q;
`endif
endmodule

// File: tb/tb_rv32_writeback.sv
// tb_rv32_writeback: directed-vector bench for rv32_writeback with hand-computed expectations.
module tb_rv32_writeback;
  import rv32_wb_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cmp_count = 0;
  int   err_count = 0;

  rv32_wb_if bus ();
  rv32_writeback dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wr, input logic [31:0] res,
                       input logic mr, input logic [1:0] w, input logic z);
    bus.valid_in           = 1'b1;
    bus.rd_in              = rd;
    bus.rd_write_in        = wr;
    bus.result_in          = res;
    bus.mem_read_in        = mr;
    bus.mem_width_in       = w;
    bus.mem_zero_extend_in = z;
  endtask

  task automatic clear();
    bus.valid_in = 1'b0;
    bus.flush_in = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    reset = 1'b0;
    cmp_count += 5;
    if (bus.rd_out !== 5'd0) begin err_count++; $display("FAIL reset_rd got %0d want 0", bus.rd_out); end
    if (bus.rd_write_out !== 1'b0) begin err_count++; $display("FAIL reset_wr got %b want 0", bus.rd_write_out); end
    if (bus.rd_value_out !== 32'd0) begin err_count++; $display("FAIL reset_val got %h want 0", bus.rd_value_out); end
    if (bus.retire_out !== 1'b0) begin err_count++; $display("FAIL reset_retire got %b want 0", bus.retire_out); end
    if (bus.stall_out !== 1'b0) begin err_count++; $display("FAIL reset_stall got %b want 0", bus.stall_out); end
  endtask

  task automatic test_alu();
    issue(5'd5, 1'b1, 32'h1234_5678, 1'b0, RV32_MEM_WIDTH_WORD, 1'b0);
    step();
    clear();
    cmp_count++;
    if (bus.rd_write_out !== 1'b0) begin err_count++; $display("FAIL alu_early got %b want 0", bus.rd_write_out); end
    step();
    cmp_count += 4;
    if (bus.rd_write_out !== 1'b1) begin err_count++; $display("FAIL alu_wr got %b want 1", bus.rd_write_out); end
    if (bus.rd_out !== 5'd5) begin err_count++; $display("FAIL alu_rd got %0d want 5", bus.rd_out); end
    if (bus.rd_value_out !== 32'h1234_5678) begin err_count++; $display("FAIL alu_val got %h want 12345678", bus.rd_value_out); end
    if (bus.retire_out !== 1'b1) begin err_count++; $display("FAIL alu_retire got %b want 1", bus.retire_out); end
    step();
    cmp_count += 2;
    if (bus.rd_write_out !== 1'b0) begin err_count++; $display("FAIL alu_pulse_wr got %b want 0", bus.rd_write_out); end
    if (bus.retire_out !== 1'b0) begin err_count++; $display("FAIL alu_pulse_retire got %b want 0", bus.retire_out); end
  endtask

  task automatic test_load_wait();
    bus.mem_ready_in = 1'b0;
    issue(5'd7, 1'b1, 32'h0000_1003, 1'b1, RV32_MEM_WIDTH_BYTE, 1'b0);
    step();
    clear();
    for (int i = 0; i < 3; i++) begin
      cmp_count += 2;
      if (bus.stall_out !== 1'b1) begin err_count++; $display("FAIL lb_stall cycle %0d got %b want 1", i, bus.stall_out); end
      if (bus.retire_out !== 1'b0) begin err_count++; $display("FAIL lb_wait_retire cycle %0d got %b want 0", i, bus.retire_out); end
      step();
    end
    bus.mem_ready_in      = 1'b1;
    bus.mem_read_value_in = 32'h80AB_CDEF;
    #1;
    cmp_count++;
    if (bus.stall_out !== 1'b0) begin err_count++; $display("FAIL lb_stall_drop got %b want 0", bus.stall_out); end
    step();
    bus.mem_ready_in = 1'b0;
    cmp_count += 4;
    if (bus.rd_write_out !== 1'b1) begin err_count++; $display("FAIL lb_wr got %b want 1", bus.rd_write_out); end
    if (bus.rd_out !== 5'd7) begin err_count++; $display("FAIL lb_rd got %0d want 7", bus.rd_out); end
    if (bus.rd_value_out !== 32'hFFFF_FF80) begin err_count++; $display("FAIL lb_val got %h want ffffff80", bus.rd_value_out); end
    if (bus.retire_out !== 1'b1) begin err_count++; $display("FAIL lb_retire got %b want 1", bus.retire_out); end
    step();
  endtask

  task automatic test_load_align();
    logic [31:0] addr [8];
    logic [31:0] data [8];
    logic [31:0] expv [8];
    logic [1:0]  wid  [8];
    logic        zx   [8];
    addr[0] = 32'h3; data[0] = 32'h80AB_CDEF; wid[0] = RV32_MEM_WIDTH_BYTE; zx[0] = 1'b1; expv[0] = 32'h0000_0080;
    addr[1] = 32'h2; data[1] = 32'h8001_0000; wid[1] = RV32_MEM_WIDTH_HALF; zx[1] = 1'b0; expv[1] = 32'hFFFF_8001;
    addr[2] = 32'h2; data[2] = 32'h8001_0000; wid[2] = RV32_MEM_WIDTH_HALF; zx[2] = 1'b1; expv[2] = 32'h0000_8001;
    addr[3] = 32'h3; data[3] = 32'hDEAD_BEEF; wid[3] = RV32_MEM_WIDTH_WORD; zx[3] = 1'b0; expv[3] = 32'hDEAD_BEEF;
    addr[4] = 32'h1; data[4] = 32'h1357_9BDF; wid[4] = 2'b11;               zx[4] = 1'b0; expv[4] = 32'h1357_9BDF;
    addr[5] = 32'h3; data[5] = 32'h7FFF_1234; wid[5] = RV32_MEM_WIDTH_HALF; zx[5] = 1'b0; expv[5] = 32'h0000_7FFF;
    addr[6] = 32'h1; data[6] = 32'h1234_5678; wid[6] = RV32_MEM_WIDTH_BYTE; zx[6] = 1'b0; expv[6] = 32'h0000_0056;
    addr[7] = 32'h0; data[7] = 32'h0000_00F0; wid[7] = RV32_MEM_WIDTH_BYTE; zx[7] = 1'b0; expv[7] = 32'hFFFF_FFF0;
    for (int i = 0; i < 8; i++) begin
      issue(5'(10 + i), 1'b1, addr[i], 1'b1, wid[i], zx[i]);
      step();
      clear();
      bus.mem_ready_in      = 1'b1;
      bus.mem_read_value_in = data[i];
      step();
      bus.mem_ready_in = 1'b0;
      cmp_count += 2;
      if (bus.rd_write_out !== 1'b1) begin err_count++; $display("FAIL align%0d_wr got %b want 1", i, bus.rd_write_out); end
      if (bus.rd_value_out !== expv[i]) begin err_count++; $display("FAIL align%0d_val got %h want %h", i, bus.rd_value_out, expv[i]); end
    end
    step();
  endtask

  task automatic test_x0_flush();
    issue(5'd0, 1'b1, 32'hAAAA_5555, 1'b0, RV32_MEM_WIDTH_WORD, 1'b0);
    step();
    clear();
    step();
    cmp_count += 2;
    if (bus.rd_write_out !== 1'b0) begin err_count++; $display("FAIL x0_wr got %b want 0", bus.rd_write_out); end
    if (bus.retire_out !== 1'b1) begin err_count++; $display("FAIL x0_retire got %b want 1", bus.retire_out); end
    issue(5'd9, 1'b1, 32'h0000_0099, 1'b0, RV32_MEM_WIDTH_WORD, 1'b0);
    bus.flush_in = 1'b1;
    step();
    clear();
    for (int i = 0; i < 2; i++) begin
      step();
      cmp_count += 2;
      if (bus.rd_write_out !== 1'b0) begin err_count++; $display("FAIL flush_wr cycle %0d got %b want 0", i, bus.rd_write_out); end
      if (bus.retire_out !== 1'b0) begin err_count++; $display("FAIL flush_retire cycle %0d got %b want 0", i, bus.retire_out); end
    end
  endtask

  task automatic test_reset_load_wait();
    bus.mem_ready_in = 1'b0;
    issue(5'd4, 1'b1, 32'h0000_2000, 1'b1, RV32_MEM_WIDTH_WORD, 1'b0);
    step();
    clear();
    cmp_count++;
    if (bus.stall_out !== 1'b1) begin err_count++; $display("FAIL rst_lw_stall got %b want 1", bus.stall_out); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.mem_ready_in      = 1'b1;
    bus.mem_read_value_in = 32'hCAFE_F00D;
    #1;
    cmp_count++;
    if (bus.stall_out !== 1'b0) begin err_count++; $display("FAIL rst_lw_stall_clr got %b want 0", bus.stall_out); end
    for (int i = 0; i < 2; i++) begin
      step();
      cmp_count += 2;
      if (bus.rd_write_out !== 1'b0) begin err_count++; $display("FAIL rst_lw_wr cycle %0d got %b want 0", i, bus.rd_write_out); end
      if (bus.retire_out !== 1'b0) begin err_count++; $display("FAIL rst_lw_retire cycle %0d got %b want 0", i, bus.retire_out); end
    end
    bus.mem_ready_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(5'd1, 1'b1, 32'h0000_0101, 1'b0, RV32_MEM_WIDTH_WORD, 1'b0);
    step();
    issue(5'd2, 1'b1, 32'h0000_0102, 1'b0, RV32_MEM_WIDTH_WORD, 1'b0);
    step();
    cmp_count += 2;
    if (bus.rd_write_out !== 1'b1 || bus.rd_out !== 5'd1) begin err_count++; $display("FAIL b2b_w1 got wr=%b rd=%0d want wr=1 rd=1", bus.rd_write_out, bus.rd_out); end
    if (bus.rd_value_out !== 32'h0000_0101) begin err_count++; $display("FAIL b2b_v1 got %h want 00000101", bus.rd_value_out); end
    bus.stall_in = 1'b1;
    issue(5'd3, 1'b1, 32'h0000_0103, 1'b0, RV32_MEM_WIDTH_WORD, 1'b0);
    step();
    cmp_count += 2;
    if (bus.rd_write_out !== 1'b1 || bus.rd_out !== 5'd2) begin err_count++; $display("FAIL b2b_w2 got wr=%b rd=%0d want wr=1 rd=2", bus.rd_write_out, bus.rd_out); end
    if (bus.rd_value_out !== 32'h0000_0102) begin err_count++; $display("FAIL b2b_v2 got %h want 00000102", bus.rd_value_out); end
`ifdef RV32_WB_BYPASS_EN
    cmp_count++;
    if (bus.bypass_valid_out !== 1'b1 || bus.bypass_rd_out !== 5'd1 || bus.bypass_value_out !== 32'h0000_0101) begin
      err_count++; $display("FAIL byp1 got v=%b rd=%0d val=%h want v=1 rd=1 val=00000101", bus.bypass_valid_out, bus.bypass_rd_out, bus.bypass_value_out);
    end
`endif
    step();
    cmp_count++;
    if (bus.rd_write_out !== 1'b0) begin err_count++; $display("FAIL b2b_dup got %b want 0", bus.rd_write_out); end
`ifdef RV32_WB_BYPASS_EN
    cmp_count++;
    if (bus.bypass_valid_out !== 1'b1 || bus.bypass_rd_out !== 5'd2 || bus.bypass_value_out !== 32'h0000_0102) begin
      err_count++; $display("FAIL byp2 got v=%b rd=%0d val=%h want v=1 rd=2 val=00000102", bus.bypass_valid_out, bus.bypass_rd_out, bus.bypass_value_out);
    end
`endif
    bus.stall_in = 1'b0;
    step();
    clear();
    cmp_count++;
    if (bus.rd_write_out !== 1'b0) begin err_count++; $display("FAIL b2b_gap got %b want 0", bus.rd_write_out); end
    step();
    cmp_count += 2;
    if (bus.rd_write_out !== 1'b1 || bus.rd_out !== 5'd3) begin err_count++; $display("FAIL b2b_w3 got wr=%b rd=%0d want wr=1 rd=3", bus.rd_write_out, bus.rd_out); end
    if (bus.rd_value_out !== 32'h0000_0103) begin err_count++; $display("FAIL b2b_v3 got %h want 00000103", bus.rd_value_out); end
    step();
    cmp_count++;
    if (bus.rd_write_out !== 1'b0) begin err_count++; $display("FAIL b2b_tail got %b want 0", bus.rd_write_out); end
`ifdef RV32_WB_BYPASS_EN
    cmp_count++;
    if (bus.bypass_valid_out !== 1'b1 || bus.bypass_rd_out !== 5'd3 || bus.bypass_value_out !== 32'h0000_0103) begin
      err_count++; $display("FAIL byp3 got v=%b rd=%0d val=%h want v=1 rd=3 val=00000103", bus.bypass_valid_out, bus.bypass_rd_out, bus.bypass_value_out);
    end
`endif
  endtask

  initial begin
    bus.stall_in           = 1'b0;
    bus.flush_in           = 1'b0;
    bus.valid_in           = 1'b0;
    bus.rd_in              = '0;
    bus.rd_write_in        = 1'b0;
    bus.result_in          = '0;
    bus.mem_read_in        = 1'b0;
    bus.mem_width_in       = RV32_MEM_WIDTH_WORD;
    bus.mem_zero_extend_in = 1'b0;
    bus.mem_ready_in       = 1'b0;
    bus.mem_read_value_in  = '0;
    test_reset();
    test_alu();
    test_load_wait();
    test_load_align();
    test_x0_flush();
    test_reset_load_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end
endmodule
